// File: rtl/fwnoc_router_ingress_mgr.sv
// Ingress manager for one router input: it decodes the packet header and
// steers each flit through a single holding register to one of four egress ports.
module fwnoc_router_ingress_mgr #(
  parameter int SEL_LSB = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_dat,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [31:0] o0_dat,
  output logic [31:0] o1_dat,
  output logic [31:0] o2_dat,
  output logic [31:0] o3_dat,
  output logic        o0_valid,
  output logic        o1_valid,
  output logic        o2_valid,
  output logic        o3_valid,
  input  logic        o0_ready,
  input  logic        o1_ready,
  input  logic        o2_ready,
  input  logic        o3_ready,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  logic [0:0]  state;
  logic [7:0]  remain;
  logic [1:0]  sel;
  logic [31:0] hold_dat;
  logic [1:0]  hold_sel;
  logic        hold_valid;

  logic        sel_ready;
  logic        take;
  logic        give;
  logic [1:0]  hdr_sel;
  logic [7:0]  hdr_len;
  logic [1:0]  flit_sel;

  assign hdr_sel = i_dat[SEL_LSB+1:SEL_LSB];
  assign hdr_len = i_dat[7:0];

  // Only the egress port that owns the held flit can release it.
  always_comb begin
    sel_ready = 1'b0;
    case (hold_sel)
      2'd0:    sel_ready = o0_ready;
      2'd1:    sel_ready = o1_ready;
      2'd2:    sel_ready = o2_ready;
      default: sel_ready = o3_ready;
    endcase
  end

  assign i_ready  = !hold_valid || sel_ready;
  assign take     = i_valid && i_ready;
  assign give     = hold_valid && sel_ready;
  assign flit_sel = (state == IDLE) ? hdr_sel : sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      remain <= 8'd0;
      sel    <= 2'd0;
    end else if (take) begin
      if (state == IDLE) begin
        sel <= hdr_sel;
        if (hdr_len != 8'd0) begin
          remain <= hdr_len;
          state  <= BODY;
        end
      end else begin
        remain <= remain - 8'd1;
        if (remain == 8'd1) begin
          state <= IDLE;
        end
      end
    end
  end

  // A same-cycle drain and refill simply overwrites, so no bubble appears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_dat   <= 32'd0;
      hold_sel   <= 2'd0;
      hold_valid <= 1'b0;
    end else if (take) begin
      hold_dat   <= i_dat;
      hold_sel   <= flit_sel;
      hold_valid <= 1'b1;
    end else if (give) begin
      hold_valid <= 1'b0;
    end
  end

  assign o0_dat   = hold_dat;
  assign o1_dat   = hold_dat;
  assign o2_dat   = hold_dat;
  assign o3_dat   = hold_dat;
  assign o0_valid = hold_valid && (hold_sel == 2'd0);
  assign o1_valid = hold_valid && (hold_sel == 2'd1);
  assign o2_valid = hold_valid && (hold_sel == 2'd2);
  assign o3_valid = hold_valid && (hold_sel == 2'd3);
  assign busy     = (state == BODY);

endmodule

// File: tb/tb_fwnoc_router_ingress_mgr.sv
// Directed self-checking bench for fwnoc_router_ingress_mgr.
// Inputs change on the falling edge; outputs are checked there too.
module tb_fwnoc_router_ingress_mgr;

  logic        clock;
  logic        reset;
  logic [31:0] i_dat;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o0_dat, o1_dat, o2_dat, o3_dat;
  logic        o0_valid, o1_valid, o2_valid, o3_valid;
  logic [3:0]  ordy;
  logic        busy;

  logic [31:0] od [4];
  logic        ov [4];

  int tests;
  int fails;

  assign od[0] = o0_dat;
  assign od[1] = o1_dat;
  assign od[2] = o2_dat;
  assign od[3] = o3_dat;
  assign ov[0] = o0_valid;
  assign ov[1] = o1_valid;
  assign ov[2] = o2_valid;
  assign ov[3] = o3_valid;

  fwnoc_router_ingress_mgr #(.SEL_LSB(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .i_dat    (i_dat),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .o0_dat   (o0_dat),
    .o1_dat   (o1_dat),
    .o2_dat   (o2_dat),
    .o3_dat   (o3_dat),
    .o0_valid (o0_valid),
    .o1_valid (o1_valid),
    .o2_valid (o2_valid),
    .o3_valid (o3_valid),
    .o0_ready (ordy[0]),
    .o1_ready (ordy[1]),
    .o2_ready (ordy[2]),
    .o3_ready (ordy[3]),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_dat   = 32'd0;
    ordy    = 4'hF;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clock);
      if (ph == 1) begin
        reset = 1'b0;
        @(negedge clock);
      end
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (ov[p] !== 1'b0) begin
          fails++;
          $display("FAIL reset_valid ph=%0d p=%0d got %0b want 0", ph, p, ov[p]);
        end
        tests++;
        if (od[p] !== 32'd0) begin
          fails++;
          $display("FAIL reset_dat ph=%0d p=%0d got %h want 0", ph, p, od[p]);
        end
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_busy ph=%0d got %0b want 0", ph, busy);
      end
      tests++;
      if (i_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_iready ph=%0d got %0b want 1", ph, i_ready);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] f [4];
    f = '{32'h0000_0203, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    ordy = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (ov[p] !== (p == 2 && c >= 1 && c <= 4)) begin
          fails++;
          $display("FAIL basic_valid c=%0d p=%0d got %0b", c, p, ov[p]);
        end
      end
      if (c >= 1 && c <= 4) begin
        tests++;
        if (od[2] !== f[c-1]) begin
          fails++;
          $display("FAIL basic_dat c=%0d got %h want %h", c, od[2], f[c-1]);
        end
      end
      tests++;
      if (busy !== (c >= 1 && c <= 3)) begin
        fails++;
        $display("FAIL basic_busy c=%0d got %0b", c, busy);
      end
      if (c < 4) begin
        i_valid = 1'b1;
        i_dat   = f[c];
      end else begin
        i_valid = 1'b0;
        i_dat   = 32'd0;
      end
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] f [3];
    int          ep [5];
    f  = '{32'h0000_0100, 32'h0000_0301, 32'h0000_00B1};
    ep = '{-1, 1, 3, 3, -1};
    ordy = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (ov[p] !== (p == ep[c])) begin
          fails++;
          $display("FAIL zlen_valid c=%0d p=%0d got %0b", c, p, ov[p]);
        end
      end
      if (ep[c] >= 0) begin
        tests++;
        if (od[ep[c]] !== f[c-1]) begin
          fails++;
          $display("FAIL zlen_dat c=%0d got %h want %h", c, od[ep[c]], f[c-1]);
        end
      end
      tests++;
      if (busy !== (c == 2)) begin
        fails++;
        $display("FAIL zlen_busy c=%0d got %0b", c, busy);
      end
      if (c < 3) begin
        i_valid = 1'b1;
        i_dat   = f[c];
      end else begin
        i_valid = 1'b0;
        i_dat   = 32'd0;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] f  [3];
    logic        rd [7];
    logic        ev [7];
    logic [31:0] ed [7];
    logic        er [7];
    int          idx;
    f  = '{32'h0000_0002, 32'h0000_00C1, 32'h0000_00C2};
    rd = '{1, 0, 0, 1, 1, 1, 1};
    ev = '{0, 1, 1, 1, 1, 1, 0};
    ed = '{0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002,
           32'h0000_00C1, 32'h0000_00C2, 0};
    er = '{1, 0, 0, 1, 1, 1, 1};
    idx  = 0;
    ordy = 4'hF;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      tests++;
      if (ov[0] !== ev[c]) begin
        fails++;
        $display("FAIL stall_valid c=%0d got %0b want %0b", c, ov[0], ev[c]);
      end
      if (ev[c]) begin
        tests++;
        if (od[0] !== ed[c]) begin
          fails++;
          $display("FAIL stall_dat c=%0d got %h want %h", c, od[0], ed[c]);
        end
      end
      tests++;
      if ((ov[1] | ov[2] | ov[3]) !== 1'b0) begin
        fails++;
        $display("FAIL stall_other c=%0d got %0b%0b%0b", c, ov[1], ov[2], ov[3]);
      end
      ordy[0] = rd[c];
      if (idx < 3) begin
        i_valid = 1'b1;
        i_dat   = f[idx];
      end else begin
        i_valid = 1'b0;
        i_dat   = 32'd0;
      end
      #1;
      tests++;
      if (i_ready !== er[c]) begin
        fails++;
        $display("FAIL stall_iready c=%0d got %0b want %0b", c, i_ready, er[c]);
      end
      if (i_valid && i_ready) idx++;
    end
  endtask

  task automatic test_blocked();
    ordy    = 4'b0111;
    i_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c >= 1 && c <= 5) begin
        tests++;
        if (ov[3] !== 1'b1 || od[3] !== 32'h0000_0302) begin
          fails++;
          $display("FAIL blk_hold c=%0d got %0b/%h want 1/00000302", c, ov[3], od[3]);
        end
      end
      if (c == 7 || c == 8) begin
        tests++;
        if (ov[3] !== 1'b1 || od[3] !== (c == 7 ? 32'h0000_00D1 : 32'h0000_00D2)) begin
          fails++;
          $display("FAIL blk_drain c=%0d got %0b/%h", c, ov[3], od[3]);
        end
      end
      if (c == 9) begin
        tests++;
        if (ov[3] !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL blk_end got valid=%0b busy=%0b want 0/0", ov[3], busy);
        end
      end
      tests++;
      if (ov[0] !== 1'b0) begin
        fails++;
        $display("FAIL blk_o0 c=%0d got %0b want 0", c, ov[0]);
      end
      if (c == 6) ordy = 4'hF;
      i_valid = (c <= 7);
      i_dat   = (c == 0) ? 32'h0000_0302 : (c == 7) ? 32'h0000_00D2 : 32'h0000_00D1;
      #1;
      if (c >= 1 && c <= 5) begin
        tests++;
        if (i_ready !== 1'b0) begin
          fails++;
          $display("FAIL blk_iready c=%0d got %0b want 0", c, i_ready);
        end
      end
    end
    i_valid = 1'b0;
  endtask

  function automatic logic [31:0] long_flit(int k);
    if (k == 0) return 32'h0000_01FF;
    if (k == 256) return 32'h0000_0000;
    return 32'hDEAD_0000 | 32'(k);
  endfunction

  task automatic test_long();
    ordy = 4'hF;
    for (int c = 0; c < 259; c++) begin
      @(negedge clock);
      if (c >= 1 && c <= 256) begin
        tests++;
        if (ov[1] !== 1'b1 || od[1] !== long_flit(c - 1) || ov[0] !== 1'b0) begin
          fails++;
          $display("FAIL long_out c=%0d got %0b/%h want 1/%h", c, ov[1], od[1], long_flit(c - 1));
        end
      end
      if (c == 257) begin
        tests++;
        if (ov[0] !== 1'b1 || od[0] !== 32'd0 || ov[1] !== 1'b0) begin
          fails++;
          $display("FAIL long_hdr got o0=%0b/%h o1=%0b want 1/0/0", ov[0], od[0], ov[1]);
        end
      end
      if (c >= 1) begin
        tests++;
        if (busy !== (c <= 255)) begin
          fails++;
          $display("FAIL long_busy c=%0d got %0b", c, busy);
        end
      end
      i_valid = (c <= 256);
      i_dat   = (c <= 256) ? long_flit(c) : 32'd0;
      #1;
      if (c <= 256) begin
        tests++;
        if (i_ready !== 1'b1) begin
          fails++;
          $display("FAIL long_iready c=%0d got %0b want 1", c, i_ready);
        end
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] f [4];
    f = '{32'h0000_0205, 32'h0000_00E1, 32'h0000_00E2, 32'h0000_00E3};
    ordy = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      i_valid = 1'b1;
      i_dat   = f[c];
    end
    @(negedge clock);
    tests++;
    if (ov[2] !== 1'b1 || od[2] !== f[2] || busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre got %0b/%h busy=%0b want 1/%h/1", ov[2], od[2], busy, f[2]);
    end
    i_dat = f[3];
    #2;
    reset = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) begin
      tests++;
      if (ov[p] !== 1'b0 || od[p] !== 32'd0) begin
        fails++;
        $display("FAIL rmid_clear p=%0d got %0b/%h want 0/0", p, ov[p], od[p]);
      end
    end
    tests++;
    if (busy !== 1'b0 || i_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_ctl got busy=%0b iready=%0b want 0/1", busy, i_ready);
    end
    i_valid = 1'b0;
    @(negedge clock);
    reset   = 1'b0;
    i_valid = 1'b1;
    i_dat   = 32'h0000_0000;
    @(negedge clock);
    i_valid = 1'b0;
    tests++;
    if (ov[0] !== 1'b1 || od[0] !== 32'd0 || ov[2] !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_hdr got o0=%0b/%h o2=%0b busy=%0b want 1/0/0/0", ov[0], od[0], ov[2], busy);
    end
    @(negedge clock);
    tests++;
    if (ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL rmid_done got %0b want 0", ov[0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_blocked();
    test_long();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwnoc_router_ingress_mgr.md
FWNOC_ROUTER_INGRESS_MGR -- requirements
Module: fwnoc_router_ingress_mgr

Interface
REQ-001 Parameter: SEL_LSB, 8, bit position of the 2-bit output-select field in a header flit.
REQ-002 Port: clock  input  1  clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_dat  input  32  ingress flit data.
REQ-005 Port: i_valid  input  1  ingress flit valid.
REQ-006 Port: i_ready  output  1  ingress flit accept.
REQ-007 Ports: o0_dat..o3_dat  output  32 each  egress flit data, one per output port.
REQ-008 Ports: o0_valid..o3_valid  output  1 each  egress flit valid, one per output port.
REQ-009 Ports: o0_ready..o3_ready  input  1 each  egress accept, one per output port.
REQ-010 Port: busy  output  1  high while a packet body is outstanding (state BODY).

Function
REQ-011 The block SHALL transfer an ingress flit on a cycle with i_valid && i_ready, and egress port n on a cycle with on_valid && on_ready.
REQ-012 Header flit format SHALL be: [SEL_LSB+1:SEL_LSB] output select (0..3); [7:0] body length L (0..255 flits following the header); remaining bits carried unmodified.
REQ-013 The FSM SHALL have states IDLE (next accepted flit is a header) and BODY (next accepted flit is body).
REQ-014 IDLE, header accepted, L==0: the block SHALL stay in IDLE and latch sel.
REQ-015 IDLE, header accepted, L>0: the block SHALL latch sel, load remain=L, and go to BODY.
REQ-016 BODY, flit accepted: the block SHALL decrement remain; on remain==1 it SHALL return to IDLE.
REQ-017 Body flits SHALL be routed to the sel latched from their own packet's header.
REQ-018 The block SHALL contain one output holding register (hold_dat, hold_sel, hold_valid); accepted flits load it, so each flit appears at egress exactly 1 cycle after acceptance.
REQ-019 on_dat SHALL equal hold_dat for all n; on_valid SHALL equal hold_valid && (hold_sel==n); at most one on_valid SHALL be high at a time.
REQ-020 i_ready SHALL equal !hold_valid || o[hold_sel]_ready (combinational path from the selected egress ready to i_ready).
REQ-021 Transfer-out and transfer-in in the same cycle SHALL reload the holding register with no bubble, sustaining 1 flit/cycle.
REQ-022 Transfer-out without transfer-in SHALL clear hold_valid; no transfer-out SHALL hold hold_dat/hold_sel/hold_valid stable.
REQ-023 A header for a different output SHALL be accepted only once the previous flit has drained per REQ-020; no reordering or dropping.
REQ-024 Ready on non-selected egress ports SHALL be ignored.
REQ-025 The remain counter SHALL be 8 bits and SHALL never wrap: no decrement in IDLE, no body flits beyond L.
REQ-026 busy SHALL be high iff state==BODY.

Reset
REQ-027 On reset the block SHALL set: state=IDLE, remain=0, sel=0, hold_valid=0, hold_dat=0, hold_sel=0.
REQ-028 During and immediately after reset: all on_valid=0, all on_dat=0, busy=0, i_ready=1.
REQ-029 Reset mid-packet SHALL abandon the packet; the next accepted flit after reset deasserts SHALL be treated as a header.

Verification
REQ-030 Header 0x0000_0203 (sel=2, L=3) + 3 body flits, o2_ready=1 always -> 4 flits on o2 on consecutive cycles, 1-cycle latency; busy high for 3 cycles; o0/o1/o3_valid never high.
REQ-031 Header 0x0000_0100 (L=0, sel=1) then header 0x0000_0301 + 1 flit -> one flit on o1, then two flits on o3; state IDLE at end.
REQ-032 Packet to o0 with o0_ready toggling 1,0,0,1 and i_valid=1 -> i_ready low exactly while hold_valid && !o0_ready; o0_dat stable while stalled; no loss or duplication.
REQ-033 o3_ready=0, o0_ready=1, packet to o3 -> i_ready stays 0 after the first flit; o0_valid stays 0.
REQ-034 Header L=255 to o1, full-rate stream -> 256 flits out; busy falls on acceptance of the 255th body flit; the next flit is decoded as a header.
REQ-035 Reset asserted after 2 of 5 body flits -> outputs cleared asynchronously; after release, flit 0x0000_0000 is routed to o0 as an L=0 header.
